imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 97 +++++++++
 tb/tb_imem_loader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams bytes into instruction memory as big-endian words, then checks a trailing XOR checksum.
// The CPU is held in clear while loading and afterwards unless the last load completed cleanly.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        idx;
    logic [23:0]       word;
    logic [7:0]        csum;
    logic              take;

    assign take = in_valid && in_ready;

    // last = len-1 wraps len=0 to the all-ones address, giving 2^ADDR_W words
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            cpu_clr  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            last     <= '0;
            addr     <= '0;
            idx      <= '0;
            word     <= '0;
            csum     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    last     <= len - 1'b1;
                    addr     <= '0;
                    idx      <= '0;
                    csum     <= '0;
                    err      <= 1'b0;
                    busy     <= 1'b1;
                    cpu_clr  <= 1'b1;
                    in_ready <= 1'b1;
                    state    <= RECV;
                end
                RECV: if (take) begin
                    word <= {word[15:0], in_data};
                    csum <= csum ^ in_data;
                    idx  <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        mem_addr <= addr;
                        mem_data <= {word, in_data};
                        mem_wren <= 1'b1;
                        in_ready <= 1'b0;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    mem_wren <= 1'b0;
                    addr     <= addr + 1'b1;
                    in_ready <= 1'b1;
                    state    <= (addr == last) ? CHECK : RECV;
                end
                CHECK: if (take) begin
                    err      <= in_data != csum;
                    done     <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= DONE;
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    cpu_clr <= err;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads checked against a word/checksum model built from the byte stream.
module tb_imem_loader;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready, mem_wren, cpu_clr, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;

    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   overlap = 0;
    int   dones = 0;
    logic last_err = 1'b0;

    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];
    logic [31:0]   ws[$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk), .clr(clr), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
        .cpu_clr(cpu_clr), .busy(busy), .done(done), .err(err)
    );

    always @(posedge clk)
        if (in_valid && in_ready) begin
            xfers++;
            if (mem_wren) overlap++;
        end

    always @(negedge clk) begin
        if (mem_wren) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
        end
        if (done) begin
            dones++;
            last_err = err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_mem_wren"}, mem_wren, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_data"}, mem_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cpu_clr"}, cpu_clr, 1);
    endtask

    // offer one byte until the loader takes it; the transfer lands on the next rising edge
    task automatic push(input logic [7:0] b, input bit bub);
        int n = 0;
        forever begin
            @(negedge clk);
            if (bub && $urandom_range(0, 2) == 0) in_valid = 1'b0;
            else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) break;
            end
            if (++n > 200) begin
                check("push_timeout", 1, 0);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_load(input bit bad, input bit bub, input bit poke);
        int   wb = wa.size();
        int   db = dones;
        int   xb = xfers;
        int   ob = overlap;
        int   n = ws.size();
        int   t = 0;
        logic [7:0] cs = 8'h00;
        foreach (ws[i]) cs ^= ws[i][31:24] ^ ws[i][23:16] ^ ws[i][15:8] ^ ws[i][7:0];
        @(negedge clk);
        start = 1'b1;
        len   = AW'(n);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("cpu_clr_loading", cpu_clr, 1);
        check("err_cleared_on_start", err, 0);
        for (int i = 0; i < n; i++)
            for (int k = 3; k >= 0; k--) begin
                if (poke && i == 0 && k == 1) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    start    = 1'b1;
                    len      = AW'(n + 3);
                    @(negedge clk);
                    start = 1'b0;
                end
                push(ws[i][8*k +: 8], bub);
            end
        push(cs ^ {7'b0, bad}, bub);
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            t++;
        end while (!done && t < 50);
        check("done_seen", done, 1);
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", dones - db, 1);
        check("err_at_done", last_err, bad);
        check("err_held", err, bad);
        check("cpu_clr_idle", cpu_clr, bad);
        check("busy_idle", busy, 0);
        check("write_count", wa.size() - wb, n);
        check("bytes_taken", xfers - xb, 4 * n + 1);
        check("take_during_write", overlap - ob, 0);
        for (int i = 0; i < n && wb + i < wa.size(); i++) begin
            check("write_addr", wa[wb+i], i % (1 << AW));
            check("write_data", wd[wb+i], ws[i]);
        end
    endtask

    initial begin
        int wb;
        repeat (3) @(negedge clk);
        #1;
        reset_checks("reset");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("cpu_clr_no_load", cpu_clr, 1);

        ws = '{32'h12345678, 32'h9ABCDEF0};
        run_load(1'b0, 1'b0, 1'b0);
        run_load(1'b1, 1'b0, 1'b0);

        ws = '{$urandom()};
        run_load(1'b0, 1'b0, 1'b0);

        repeat (4) begin
            ws.delete();
            repeat ($urandom_range(1, 6)) ws.push_back($urandom());
            run_load(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        ws = '{32'hCAFEF00D, 32'h0, 32'h0};
        wb = wa.size();
        @(negedge clk);
        start = 1'b1;
        len   = 3;
        @(negedge clk);
        start = 1'b0;
        for (int k = 3; k >= 0; k--) push(ws[0][8*k +: 8], 1'b0);
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b1;
        #1;
        reset_checks("abort");
        check("abort_write_count", wa.size() - wb, 1);
        if (wa.size() > wb) check("abort_word0", wd[wb], 32'hCAFEF00D);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_late_write", wa.size() - wb, 1);
        ws = '{$urandom()};
        run_load(1'b0, 1'b0, 1'b0);

        ws.delete();
        for (int i = 0; i < 256; i++) ws.push_back(32'(i));
        run_load(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
